game_sequencer: RTL

- Synthesizable stimulus-and-score engine that sits opposite the Game_State block.
- Drives Game_State's `reset`, `control`, `i_value` and `INIT`, and consumes its `who`, `los`, `win` and `gameover` outputs.
- Runs a fixed sweep of 16 scenarios: 4 count modes × 4 init values.
- Tallies winner/loser outcomes and flags hung games with a watchdog; replaces bench-only directed stimulus with on-chip self-test.

---
 rtl/game_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Self-test sweep engine for Game_State: 16 scenarios (4 count modes x 4 init values), tallies outcomes, watchdogs hangs.
// Optional GAME_SEQ_RESULT_LOG_EN adds a 2-bit-per-scenario result_log output.
module game_sequencer #(
    parameter int COUNTER_SIZE   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              who,
    input  logic                    los,
    input  logic                    win,
    input  logic                    gameover,
    output logic                    game_rst,
    output logic [1:0]              control,
    output logic [COUNTER_SIZE-1:0] i_value,
    output logic                    INIT,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              scen_num,
    output logic [4:0]              win_games,
    output logic [4:0]              lose_games,
    output logic                    timeout_err
`ifdef GAME_SEQ_RESULT_LOG_EN
    ,
    output logic [31:0]             result_log
`endif
);

    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_RECORD = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // state_q is the FSM observation point for bound checkers.
    state_e           state_q, state_d;
    logic [3:0]       scen_num_q, scen_num_d;
    logic [4:0]       win_q, win_d;
    logic [4:0]       lose_q, lose_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]  watchdog_q, watchdog_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             gameover_q;
    logic [1:0]       who_q, who_d;
`ifdef GAME_SEQ_RESULT_LOG_EN
    logic [31:0]      log_q, log_d;
`endif

    logic go_edge, wd_expired, gap_end;
    logic unused_mon;

    assign go_edge    = gameover & ~gameover_q;
    assign wd_expired = (watchdog_q == WD_LAST);
    assign gap_end    = (gap_cnt_q == GAP_LAST);
    // los/win duplicate information carried by who/gameover.
    assign unused_mon = los ^ win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            scen_num_q    <= '0;
            win_q         <= '0;
            lose_q        <= '0;
            timeout_err_q <= 1'b0;
            watchdog_q    <= '0;
            gap_cnt_q     <= '0;
            gameover_q    <= 1'b0;
            who_q         <= '0;
`ifdef GAME_SEQ_RESULT_LOG_EN
            log_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            scen_num_q    <= scen_num_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            timeout_err_q <= timeout_err_d;
            watchdog_q    <= watchdog_d;
            gap_cnt_q     <= gap_cnt_d;
            gameover_q    <= gameover;
            who_q         <= who_d;
`ifdef GAME_SEQ_RESULT_LOG_EN
            log_q         <= log_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            S_LOAD:         state_d = S_RUN;
            S_RUN: begin
                // A result arriving on the expiry cycle still counts as a result.
                if (go_edge)         state_d = S_RECORD;
                else if (wd_expired) state_d = S_GAP;
            end
            S_RECORD:       state_d = S_GAP;
            S_GAP: begin
                if (gap_end) state_d = (scen_num_q == 4'd15) ? S_DONE : S_LOAD;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scen_num_d    = scen_num_q;
        win_d         = win_q;
        lose_d        = lose_q;
        timeout_err_d = timeout_err_q;
        watchdog_d    = watchdog_q;
        gap_cnt_d     = gap_cnt_q;
        who_d         = who_q;
`ifdef GAME_SEQ_RESULT_LOG_EN
        log_d         = log_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    scen_num_d    = '0;
                    win_d         = '0;
                    lose_d        = '0;
                    timeout_err_d = 1'b0;
`ifdef GAME_SEQ_RESULT_LOG_EN
                    log_d         = '0;
`endif
                end
            end
            S_LOAD: watchdog_d = '0;
            S_RUN: begin
                watchdog_d = watchdog_q + 1'b1;
                if (go_edge) begin
                    who_d = who;
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
`ifdef GAME_SEQ_RESULT_LOG_EN
                    log_d[{scen_num_q, 1'b0} +: 2] = 2'b11;
`endif
                end
            end
            S_RECORD: begin
                if (who_q == 2'b10) begin
                    win_d = win_q + 5'd1;
`ifdef GAME_SEQ_RESULT_LOG_EN
                    log_d[{scen_num_q, 1'b0} +: 2] = 2'b10;
`endif
                end else begin
                    lose_d = lose_q + 5'd1;
`ifdef GAME_SEQ_RESULT_LOG_EN
                    log_d[{scen_num_q, 1'b0} +: 2] = 2'b01;
`endif
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    gap_cnt_d = '0;
                    if (scen_num_q != 4'd15) scen_num_d = scen_num_q + 4'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        game_rst = 1'b1;
        INIT     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD: begin
                game_rst = 1'b0;
                INIT     = 1'b1;
                busy     = 1'b1;
            end
            S_RUN, S_RECORD: begin
                game_rst = 1'b0;
                busy     = 1'b1;
            end
            S_GAP:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Scenario decode is a pure function of the index, so it holds across RUN and GAP.
    assign control = scen_num_q[3:2];
    always_comb begin
        case (scen_num_q[1:0])
            2'd0:    i_value = '0;
            2'd1:    i_value = COUNTER_SIZE'(1);
            2'd2:    i_value = COUNTER_SIZE'(2);
            default: i_value = '1;
        endcase
    end

    assign scen_num    = scen_num_q;
    assign win_games   = win_q;
    assign lose_games  = lose_q;
    assign timeout_err = timeout_err_q;
`ifdef GAME_SEQ_RESULT_LOG_EN
    assign result_log  = log_q;
`endif

endmodule
